// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter and walks it through sequential
// fetch, redirects, exception entry and halt. It runs a req/ack handshake
// toward instruction memory and a valid/ready handshake toward decode.
module fetch_sequencer #(
    parameter int              PC_W       = 13,
    parameter logic [PC_W-1:0] RESET_PC   = 'h0000,
    parameter logic [PC_W-1:0] EXC_VECTOR = 'h0180,
    parameter int              TIMEOUT    = 16
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [PC_W-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            exc,
    input  logic            halt,
    output logic            fetch_err,
    output logic [PC_W-1:0] pc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_REQ,
        S_VALID,
        S_HALTED
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [PC_W-1:0]  pc_next, inst_pc_next;
    logic [31:0]      inst_next;
    logic             valid_next, err_next, req_next, timeout_hit;

    assign imem_addr = pc;

    // Ack is only honoured while the registered request is actually high, so the
    // idle cycle right after reset neither accepts data nor counts toward timeout.
    assign timeout_hit = (state == S_REQ) && imem_req && !imem_ack &&
                         (cnt == CNT_W'(TIMEOUT - 1));

    // Next-state and next-output logic, priority exc > timeout > redirect > normal.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        cnt_next     = cnt;
        inst_next    = inst;
        inst_pc_next = inst_pc;
        valid_next   = inst_valid;
        err_next     = 1'b0;
        if (exc) begin
            pc_next    = EXC_VECTOR;
            valid_next = 1'b0;
            cnt_next   = '0;
            state_next = S_REQ;
        end else if (timeout_hit) begin
            err_next   = 1'b1;
            pc_next    = EXC_VECTOR;
            cnt_next   = '0;
            state_next = S_REQ;
        end else if (redirect_valid) begin
            pc_next    = redirect_pc & ~PC_W'(3);
            valid_next = 1'b0;
            cnt_next   = '0;
            state_next = S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req) begin
                        if (imem_ack) begin
                            inst_next    = imem_rdata;
                            inst_pc_next = pc;
                            pc_next      = pc + PC_W'(4);
                            valid_next   = 1'b1;
                            cnt_next     = '0;
                            state_next   = S_VALID;
                        end else begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end
                end
                S_VALID: begin
                    if (inst_ready) begin
                        valid_next = 1'b0;
                        state_next = halt ? S_HALTED : S_REQ;
                    end
                end
                S_HALTED: begin
                    valid_next = 1'b0;
                end
                default: begin
                    state_next = S_REQ;
                end
            endcase
        end
        req_next = (state_next == S_REQ);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            cnt        <= '0;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            cnt        <= cnt_next;
            imem_req   <= req_next;
            inst_valid <= valid_next;
            inst       <= inst_next;
            inst_pc    <= inst_pc_next;
            fetch_err  <= err_next;
        end
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the MIPS core. It owns the program counter and sequences it through sequential fetch, branch/jump redirects, exception entry and halt. It drives a req/ack handshake toward instruction memory and a valid/ready handshake toward decode. It replaces the free-running pcNext path with a stall- and redirect-aware sequencer.

## Interface
- PC_W, 13: PC width in bits; byte address, word aligned.
- RESET_PC, 13'h0000: PC loaded on reset.
- EXC_VECTOR, 13'h0180: exception and fetch-error target.
- TIMEOUT, 16: REQ cycles without ack before a fetch error is raised.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_ack  in  1  memory has returned imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  inst/inst_pc valid for decode.
- inst  out  32  fetched instruction.
- inst_pc  out  PC_W  address of inst.
- inst_ready  in  1  decode accepts inst this cycle.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  PC_W  redirect target; bits [1:0] forced to 0.
- exc  in  1  exception request.
- halt  in  1  stop fetching at next instruction boundary.
- fetch_err  out  1  one-cycle pulse on ack timeout.
- pc  out  PC_W  current fetch PC.

## Operation
- States: REQ, VALID, HALTED.
- Reset (reset=0 at an edge), from any state including mid-handshake:
  - state=REQ, pc=RESET_PC, timeout counter=0.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0, fetch_err=0.
  - imem_req is a registered output and asserts the first cycle after reset is released.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4, inst_valid<=1, go to VALID.
- VALID:
  - imem_req=0; inst and inst_pc held stable.
  - On inst_ready: inst_valid<=0; go to HALTED if halt=1, else REQ.
- HALTED:
  - imem_req=0, inst_valid=0.
  - Leaves only on redirect_valid or exc; halt=0 alone does not resume.
- Priority each cycle: reset > exc > timeout > redirect_valid > normal.
  - exc: pc<=EXC_VECTOR, inst_valid<=0, counter<=0, state<=REQ. Any same-cycle ack data is discarded.
  - redirect_valid: same as exc, but pc<=redirect_pc & ~3.
  - Either event in VALID drops the pending instruction even if inst_ready=1.
- Timeout:
  - The counter increments each REQ cycle with imem_ack=0 and clears on ack, exc, redirect or leaving REQ.
  - When it reaches TIMEOUT: fetch_err=1 for one cycle, pc<=EXC_VECTOR, counter<=0, stay in REQ.
- Arithmetic: pc+4 is modulo 2^PC_W, so 13'h1FFC wraps to 13'h0000.
- imem_req may drop without ack on redirect/exc/reset. Memory must not return a stale ack for an abandoned request.

## Timing
- imem_ack is accepted in any cycle imem_req=1, including the first REQ cycle.
- Minimum throughput: 2 cycles per instruction (REQ with ack, then VALID with ready).
- inst_valid rises the cycle after the accepted ack.
- Redirect/exc: new imem_addr appears the cycle after the event.
- fetch_err asserts the cycle after the TIMEOUT-th unacknowledged REQ cycle.
- All outputs are registered except imem_addr, which is a direct copy of pc.

## Test plan
- Sequential fetch: release reset, ack on every first REQ cycle, inst_ready=1.
  - Expect imem_addr 0x000, 0x004, 0x008.
  - inst_pc matches each address; inst_valid high every 2nd cycle.
- Backpressure: inst_ready=0 for 5 cycles at inst_pc=0x004.
  - Expect inst and inst_pc stable, imem_req=0, pc=0x008.
  - Fetch resumes at 0x008 after ready.
- Redirect in REQ with simultaneous ack, redirect_pc=0x0123.
  - Ack data is discarded; inst_valid stays 0.
  - Next imem_addr=0x0120.
- exc and redirect_valid (0x0040) in the same cycle.
  - Next imem_addr=0x0180.
  - halt then ready puts the block in HALTED; a later redirect to 0x0040 resumes fetch there.
- Timeout: imem_ack held 0.
  - fetch_err pulses exactly once after 16 REQ cycles.
  - Next imem_addr=0x0180.
- Wrap and reset:
  - Redirect to 0x1FFC and ack: next imem_addr=0x0000.
  - Assert reset=0 in VALID: next edge gives inst_valid=0, pc=0x0000, imem_req=0.
